// File: rtl/palindrome_control.sv
// Control FSM for the palindrome datapath: loads the pointers, steps them inward and reports the verdict.
// Optional step-limit abort is compiled in with `define PAL_TIMEOUT_EN (uses MAX_STEPS).
module palindrome_control #(
    parameter int MAX_STEPS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       front_ge_back,
    input  logic       a_ne_b,
    output logic       load,
    output logic       select,
    output logic       busy,
    output logic       done,
    output logic       is_palindrome,
    output logic [4:0] steps,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] STEP_LIMIT = 5'(MAX_STEPS);
    localparam logic [4:0] STEP_SAT   = 5'd31;

    state_t     state_reg, state_next;
    logic [4:0] steps_reg, steps_next;
    logic       is_pal_reg, is_pal_next;
    logic       timeout_reg, timeout_next;
    logic       limit_hit;

`ifdef PAL_TIMEOUT_EN
    assign limit_hit = (steps_reg == STEP_LIMIT);
`else
    logic unused_limit;
    assign limit_hit    = 1'b0;
    assign unused_limit = ^STEP_LIMIT;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            steps_reg   <= '0;
            is_pal_reg  <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            steps_reg   <= steps_next;
            is_pal_reg  <= is_pal_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        steps_next   = steps_reg;
        is_pal_next  = is_pal_reg;
        timeout_next = timeout_reg;
        load         = 1'b0;
        select       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = INIT;
                    steps_next   = '0;
                    is_pal_next  = 1'b0;
                    timeout_next = 1'b0;
                end
            end
            INIT: begin
                busy       = 1'b1;
                load       = 1'b1;
                state_next = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                // Met/crossed pointers win over a mismatch flag.
                if (front_ge_back) begin
                    state_next  = DONE;
                    is_pal_next = 1'b1;
                end else if (a_ne_b) begin
                    state_next  = DONE;
                    is_pal_next = 1'b0;
                end else if (limit_hit) begin
                    state_next   = DONE;
                    is_pal_next  = 1'b0;
                    timeout_next = 1'b1;
                end else begin
                    load   = 1'b1;
                    select = 1'b1;
                    if (steps_reg != STEP_SAT) begin
                        steps_next = steps_reg + 5'd1;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign is_palindrome = is_pal_reg;
    assign steps         = steps_reg;
    assign timeout       = timeout_reg;

endmodule

// File: tb/tb_palindrome_control.sv
// Directed bench for palindrome_control with a small behavioural pointer/regfile datapath model.
// Build with +define+PAL_TIMEOUT_EN to exercise the step-limit abort instead of saturation.
module tb_palindrome_control;

    logic       clk;
    logic       reset;
    logic       start;
    logic       front_ge_back;
    logic       a_ne_b;
    logic       load;
    logic       select;
    logic       busy;
    logic       done;
    logic       is_palindrome;
    logic [4:0] steps;
    logic       timeout;

    logic [7:0] mem [0:15];
    logic [3:0] base;
    logic [3:0] ending;
    logic [3:0] front;
    logic [3:0] back;
    logic       force_mode;
    logic       force_ge;
    logic       force_ne;

    int total = 0;
    int bad   = 0;

    palindrome_control #(.MAX_STEPS(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .front_ge_back (front_ge_back),
        .a_ne_b        (a_ne_b),
        .load          (load),
        .select        (select),
        .busy          (busy),
        .done          (done),
        .is_palindrome (is_palindrome),
        .steps         (steps),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front <= '0;
            back  <= '0;
        end else if (load) begin
            if (select) begin
                front <= front + 4'd1;
                back  <= back - 4'd1;
            end else begin
                front <= base;
                back  <= ending;
            end
        end
    end

    assign front_ge_back = force_mode ? force_ge : (front >= back);
    assign a_ne_b        = force_mode ? force_ne : (mem[front] != mem[back]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic load_word(input int a, input int b, input int c, input int d, input int e);
        mem[0] = 8'(a);
        mem[1] = 8'(b);
        mem[2] = 8'(c);
        mem[3] = 8'(d);
        mem[4] = 8'(e);
    endtask

    // Pattern 1,2,3,2,1 from base 0: two advances, verdict in cycle 5.
    task automatic run_pal_12321(input string name);
        load_word(1, 2, 3, 2, 1);
        base = 4'd0; ending = 4'd4; force_mode = 1'b0;
        start = 1'b1;
        check({name, "_c0_busy"}, 32'(busy), 32'd0);
        cyc(); start = 1'b0;
        check({name, "_c1_ldsel"}, 32'({load, select}), 32'b10);
        check({name, "_c1_busy"}, 32'(busy), 32'd1);
        cyc();
        check({name, "_c2_ldsel"}, 32'({load, select}), 32'b11);
        cyc();
        check({name, "_c3_ldsel"}, 32'({load, select}), 32'b11);
        cyc();
        check({name, "_c4_ldsel_done"}, 32'({load, select, done}), 32'b000);
        cyc();
        check({name, "_c5_done"}, 32'(done), 32'd1);
        check({name, "_c5_ispal"}, 32'(is_palindrome), 32'd1);
        check({name, "_c5_steps"}, 32'(steps), 32'd2);
        check({name, "_c5_timeout"}, 32'(timeout), 32'd0);
        check({name, "_c5_busy"}, 32'(busy), 32'd0);
        cyc();
        check({name, "_c6_done_low"}, 32'(done), 32'd0);
        check({name, "_c6_ispal_held"}, 32'(is_palindrome), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'd0;
        reset = 1'b0; start = 1'b0; base = '0; ending = '0;
        force_mode = 1'b0; force_ge = 1'b0; force_ne = 1'b0;

        // Reset asserted mid-cycle while idle
        #3 reset = 1'b1;
        #1;
        check("rst_outs", 32'({load, select, busy, done, is_palindrome, timeout}), 32'd0);
        check("rst_steps", 32'(steps), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        cyc();
        check("idle_outs", 32'({load, select, busy, done}), 32'd0);

        // Palindrome 1,2,3,2,1
        run_pal_12321("pal");

        // Mismatch 1,2,3,9,1: one advance then a_ne_b stops
        load_word(1, 2, 3, 9, 1);
        start = 1'b1;
        cyc(); start = 1'b0;
        check("mis_c1_ispal_clr", 32'(is_palindrome), 32'd0);
        check("mis_c1_steps_clr", 32'(steps), 32'd0);
        cyc();
        check("mis_c2_ldsel", 32'({load, select}), 32'b11);
        cyc();
        check("mis_c3_ldsel", 32'({load, select}), 32'b00);
        cyc();
        check("mis_c4_done", 32'(done), 32'd1);
        check("mis_c4_ispal", 32'(is_palindrome), 32'd0);
        check("mis_c4_steps", 32'(steps), 32'd1);
        cyc();

        // base > ending: immediate verdict, no step
        base = 4'd7; ending = 4'd3;
        start = 1'b1;
        cyc(); start = 1'b0;
        check("cross_c1_ldsel", 32'({load, select}), 32'b10);
        cyc();
        check("cross_c2_ldsel", 32'({load, select}), 32'b00);
        check("cross_c2_busy", 32'(busy), 32'd1);
        cyc();
        check("cross_c3_done", 32'(done), 32'd1);
        check("cross_c3_ispal", 32'(is_palindrome), 32'd1);
        check("cross_c3_steps", 32'(steps), 32'd0);
        check("cross_c3_sel", 32'(select), 32'd0);
        cyc();

        // start held high through a whole run: exactly one run
        load_word(1, 2, 3, 2, 1);
        base = 4'd0; ending = 4'd4;
        start = 1'b1;
        repeat (5) cyc();
        check("hold_c5_done", 32'(done), 32'd1);
        check("hold_c5_steps", 32'(steps), 32'd2);
        cyc();
        check("hold_c6_idle", 32'({busy, load, done}), 32'd0);
        start = 1'b0;
        cyc();
        check("hold_c7_idle", 32'(busy), 32'd0);

        // Reset during CHECK, then a clean run
        force_mode = 1'b1; force_ge = 1'b0; force_ne = 1'b0;
        start = 1'b1;
        cyc(); start = 1'b0;
        repeat (3) cyc();
        check("rchk_c4_steps", 32'(steps), 32'd2);
        check("rchk_c4_busy", 32'(busy), 32'd1);
        #3 reset = 1'b1;
        #1;
        check("rchk_busy", 32'(busy), 32'd0);
        check("rchk_steps", 32'(steps), 32'd0);
        check("rchk_load", 32'({load, select}), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        cyc();
        run_pal_12321("after_rst");

        // Flags forced quiet: limit abort or saturation
        force_mode = 1'b1; force_ge = 1'b0; force_ne = 1'b0;
        start = 1'b1;
        cyc(); start = 1'b0;
`ifdef PAL_TIMEOUT_EN
        cyc();
        check("to_c2_ldsel", 32'({load, select}), 32'b11);
        cyc();
        check("to_c3_ldsel", 32'({load, select}), 32'b11);
        cyc();
        check("to_c4_ldsel", 32'({load, select}), 32'b00);
        cyc();
        check("to_c5_done", 32'(done), 32'd1);
        check("to_c5_timeout", 32'(timeout), 32'd1);
        check("to_c5_ispal", 32'(is_palindrome), 32'd0);
        check("to_c5_steps", 32'(steps), 32'd2);
        cyc();
`else
        repeat (40) cyc();
        check("sat_steps", 32'(steps), 32'd31);
        check("sat_busy", 32'(busy), 32'd1);
        check("sat_timeout", 32'(timeout), 32'd0);
        check("sat_ldsel", 32'({load, select}), 32'b11);
        force_ge = 1'b1;
        cyc();
        check("sat_done", 32'(done), 32'd1);
        check("sat_ispal", 32'(is_palindrome), 32'd1);
        check("sat_final_steps", 32'(steps), 32'd31);
        cyc();
`endif
        force_mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
